// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry (save cause/epc, jump to mtvec) and mret return sequencer
module trap_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mstatus_ie_i,
  input  logic        mie_external_i,
  input  logic        mie_timer_i,
  input  logic        mie_software_i,
  input  logic        mip_external_i,
  input  logic        mip_timer_i,
  input  logic        mip_software_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_pc_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        redirect_ready_i,
  output logic        cause_we_o,
  output logic [3:0]  cause_o,
  output logic        interrupt_type_o,
  output logic        epc_we_o,
  output logic [31:0] epc_o,
  output logic        mstatus_ie_clear_o,
  output logic        mstatus_ie_set_o,
  output logic        stall_req_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);
  typedef enum logic [1:0] {IDLE, SAVE, JUMP, MRET} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cause_q, cause_d;
  logic        intr_q, intr_d;
  logic        first_q, first_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        ext, sw, tm, irq, exc;
  logic [3:0]  irq_cause, exc_cause;
  logic [31:0] vec_off;
  // source arbitration and next-state/target selection; the redirect target is latched so it stays stable while fetch stalls
  always_comb begin
    ext       = mstatus_ie_i & mie_external_i & mip_external_i;
    sw        = mstatus_ie_i & mie_software_i & mip_software_i;
    tm        = mstatus_ie_i & mie_timer_i & mip_timer_i;
    irq       = ext | sw | tm;
    exc       = illegal_i | ebreak_i | ecall_i;
    irq_cause = ext ? 4'd11 : sw ? 4'd3 : 4'd7;
    exc_cause = illegal_i ? 4'd2 : ebreak_i ? 4'd3 : 4'd11;
    vec_off   = (intr_q && mtvec_i[1:0] == 2'b01) ? {26'd0, cause_q, 2'b00} : 32'd0;
    state_d   = state_q;
    cause_d   = cause_q;
    intr_d    = intr_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    first_d   = 1'b0;
    case (state_q)
      IDLE: if (inst_valid_i) begin
        if (irq | exc) begin
          state_d = SAVE;
          cause_d = irq ? irq_cause : exc_cause;
          intr_d  = irq;
          pc_d    = inst_pc_i;
        end else if (mret_i) begin
          state_d = MRET;
          tgt_d   = mepc_i & 32'hFFFF_FFFC;
          first_d = 1'b1;
        end
      end
      SAVE: begin
        state_d = JUMP;
        tgt_d   = (mtvec_i & 32'hFFFF_FFFC) + vec_off;
      end
      JUMP, MRET: state_d = redirect_ready_i ? IDLE : state_q;
      default: state_d = IDLE;
    endcase
  end
  // state and latched trap context
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cause_q <= 4'd0;
      intr_q  <= 1'b0;
      first_q <= 1'b0;
      pc_q    <= 32'd0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      intr_q  <= intr_d;
      first_q <= first_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end
  // outputs decode from state; stall also covers the IDLE cycle that launches a sequence, and is masked during reset
  always_comb begin
    cause_we_o         = state_q == SAVE;
    cause_o            = state_q == SAVE ? cause_q : 4'd0;
    interrupt_type_o   = state_q == SAVE && intr_q;
    epc_we_o           = state_q == SAVE;
    epc_o              = state_q == SAVE ? pc_q : 32'd0;
    mstatus_ie_clear_o = state_q == SAVE;
    mstatus_ie_set_o   = state_q == MRET && first_q;
    redirect_valid_o   = state_q == JUMP || state_q == MRET;
    redirect_pc_o      = redirect_valid_o ? tgt_q : 32'd0;
    stall_req_o        = rst_ni && (state_q != IDLE || (inst_valid_i && (irq || exc || mret_i)));
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table, corner sequences and randomized run against a transaction-level model
module tb_trap_ctrl;
  logic clk_i = 0, rst_ni = 0;
  logic mstatus_ie_i = 0, mie_external_i = 0, mie_timer_i = 0, mie_software_i = 0;
  logic mip_external_i = 0, mip_timer_i = 0, mip_software_i = 0;
  logic [31:0] mtvec_i = 0, mepc_i = 0, inst_pc_i = 0;
  logic inst_valid_i = 0, ecall_i = 0, ebreak_i = 0, illegal_i = 0, mret_i = 0, redirect_ready_i = 0;
  logic cause_we_o, interrupt_type_o, epc_we_o, mstatus_ie_clear_o, mstatus_ie_set_o;
  logic stall_req_o, redirect_valid_o;
  logic [3:0] cause_o;
  logic [31:0] epc_o, redirect_pc_o;
  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  trap_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mstatus_ie_i(mstatus_ie_i),
    .mie_external_i(mie_external_i), .mie_timer_i(mie_timer_i), .mie_software_i(mie_software_i),
    .mip_external_i(mip_external_i), .mip_timer_i(mip_timer_i), .mip_software_i(mip_software_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .inst_valid_i(inst_valid_i), .inst_pc_i(inst_pc_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .illegal_i(illegal_i), .mret_i(mret_i),
    .redirect_ready_i(redirect_ready_i), .cause_we_o(cause_we_o), .cause_o(cause_o),
    .interrupt_type_o(interrupt_type_o), .epc_we_o(epc_we_o), .epc_o(epc_o),
    .mstatus_ie_clear_o(mstatus_ie_clear_o), .mstatus_ie_set_o(mstatus_ie_set_o),
    .stall_req_o(stall_req_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic expect_all(input string p, input logic cw, input logic [3:0] c, input logic it,
                            input logic ew, input logic [31:0] ep, input logic clr, input logic set,
                            input logic st, input logic rv, input logic [31:0] rpc);
    chk({p, ".cause_we"}, cause_we_o, cw);
    chk({p, ".cause"}, cause_o, c);
    chk({p, ".intr"}, interrupt_type_o, it);
    chk({p, ".epc_we"}, epc_we_o, ew);
    chk({p, ".epc"}, epc_o, ep);
    chk({p, ".ie_clear"}, mstatus_ie_clear_o, clr);
    chk({p, ".ie_set"}, mstatus_ie_set_o, set);
    chk({p, ".stall"}, stall_req_o, st);
    chk({p, ".rvalid"}, redirect_valid_o, rv);
    chk({p, ".rpc"}, redirect_pc_o, rpc);
  endtask

  // mie/mip bit order: [2]=external [1]=software [0]=timer; ev: {illegal, ebreak, ecall, mret}
  task automatic drive(input logic ie, input logic [2:0] mie, input logic [2:0] mip,
                       input logic v, input logic [3:0] ev, input logic [31:0] pc);
    mstatus_ie_i = ie;
    {mie_external_i, mie_software_i, mie_timer_i} = mie;
    {mip_external_i, mip_software_i, mip_timer_i} = mip;
    inst_valid_i = v;
    {illegal_i, ebreak_i, ecall_i, mret_i} = ev;
    inst_pc_i = pc;
  endtask

  // highest-priority hit in a 3-entry priority list (hits[2] first); -1 when none
  function automatic int first_code(input logic [2:0] hits, input int c2, input int c1, input int c0);
    if (hits[2]) return c2;
    if (hits[1]) return c1;
    if (hits[0]) return c0;
    return -1;
  endfunction

  typedef struct {
    logic ie; logic [2:0] mie; logic [2:0] mip; logic v; logic [3:0] ev;
    logic [31:0] pc; logic [31:0] tvec;
    logic act; logic [3:0] cause; logic intr; logic [31:0] tgt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 3'b001, 3'b001, 1, 4'b0000, 32'h100, 32'h8000_0000, 1, 7,  1, 32'h8000_0000};
    tbl[1]  = '{1, 3'b101, 3'b101, 1, 4'b0000, 32'h104, 32'h8000_0001, 1, 11, 1, 32'h8000_002C};
    tbl[2]  = '{0, 3'b001, 3'b001, 1, 4'b0010, 32'h200, 32'h8000_0000, 1, 11, 0, 32'h8000_0000};
    tbl[3]  = '{1, 3'b010, 3'b010, 1, 4'b1000, 32'h300, 32'h8000_0001, 1, 3,  1, 32'h8000_000C};
    tbl[4]  = '{1, 3'b111, 3'b111, 0, 4'b0000, 32'h304, 32'h8000_0000, 0, 0,  0, 32'h0};
    tbl[5]  = '{0, 3'b000, 3'b000, 1, 4'b1100, 32'h400, 32'h8000_0001, 1, 2,  0, 32'h8000_0000};
    tbl[6]  = '{0, 3'b000, 3'b000, 1, 4'b0110, 32'h404, 32'h0000_0010, 1, 3,  0, 32'h0000_0010};
    tbl[7]  = '{1, 3'b100, 3'b100, 1, 4'b0000, 32'h500, 32'h4000_0003, 1, 11, 1, 32'h4000_0000};
    tbl[8]  = '{1, 3'b111, 3'b011, 1, 4'b0000, 32'h504, 32'h4000_0002, 1, 3,  1, 32'h4000_0000};
    tbl[9]  = '{1, 3'b100, 3'b001, 1, 4'b0000, 32'h508, 32'h4000_0001, 0, 0,  0, 32'h0};
    tbl[10] = '{1, 3'b100, 3'b100, 1, 4'b0000, 32'h600, 32'hFFFF_FFF1, 1, 11, 1, 32'h0000_001C};
    tbl[11] = '{1, 3'b001, 3'b001, 1, 4'b0000, 32'h604, 32'h0000_1001, 1, 7,  1, 32'h0000_101C};

    // reset state with an active request presented
    drive(1, 3'b111, 3'b111, 1, 4'b1111, 32'h100);
    #2;
    expect_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    rst_ni = 1;

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      mtvec_i = tbl[i].tvec;
      redirect_ready_i = 0;
      drive(tbl[i].ie, tbl[i].mie, tbl[i].mip, tbl[i].v, tbl[i].ev, tbl[i].pc);
      #1 chk($sformatf("v%0d.stall_take", i), stall_req_o, tbl[i].act);
      @(posedge clk_i);
      @(negedge clk_i);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      if (tbl[i].act) begin
        expect_all($sformatf("v%0d.save", i), 1, tbl[i].cause, tbl[i].intr, 1, tbl[i].pc, 1, 0, 1, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        #1 expect_all($sformatf("v%0d.jump", i), 0, 0, 0, 0, 0, 0, 0, 1, 1, tbl[i].tgt);
        redirect_ready_i = 1;
        @(posedge clk_i);
        @(negedge clk_i);
        redirect_ready_i = 0;
        #1 expect_all($sformatf("v%0d.idle", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else
        expect_all($sformatf("v%0d.noact", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // mret with fetch back-pressure for three cycles
    begin
      int sets = 0;
      @(negedge clk_i);
      mepc_i = 32'h204;
      drive(0, 0, 0, 1, 4'b0001, 32'h208);
      #1 chk("mret.stall_take", stall_req_o, 1);
      @(posedge clk_i);
      @(negedge clk_i);
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        #1;
        chk($sformatf("mret%0d.rvalid", k), redirect_valid_o, 1);
        chk($sformatf("mret%0d.rpc", k), redirect_pc_o, 32'h204);
        chk($sformatf("mret%0d.ie_set", k), mstatus_ie_set_o, k == 0);
        sets += int'(mstatus_ie_set_o);
        if (k == 3) redirect_ready_i = 1;
        @(posedge clk_i);
        @(negedge clk_i);
      end
      redirect_ready_i = 0;
      #1;
      chk("mret.set_count", sets, 1);
      expect_all("mret.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // reset asserted in the middle of JUMP
    @(negedge clk_i);
    mtvec_i = 32'h8000_0000;
    drive(1, 3'b001, 3'b001, 1, 4'b0000, 32'h100);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    #1 chk("rstjump.pre_rvalid", redirect_valid_o, 1);
    drive(1, 3'b001, 3'b001, 1, 4'b0000, 32'h100);
    rst_ni = 0;
    #1 expect_all("rstjump", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
    mepc_i = 32'h300;
    drive(0, 0, 0, 1, 4'b0001, 32'h0);
    #1 chk("rstjump.accept_stall", stall_req_o, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1 expect_all("rstjump.mret", 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h300);
    redirect_ready_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    redirect_ready_i = 0;

    // randomized run against a transaction-level model: kind 0 idle, 1 trap, 2 mret; age counts cycles in the sequence
    begin
      int m_kind = 0, m_age = 0;
      logic [3:0] m_cause = 0;
      logic m_intr = 0;
      logic [31:0] m_epc = 0, m_tgt = 0;
      for (int n = 0; n < 800; n++) begin
        int irq_c, exc_c;
        logic take_trap, take_mret, save, redir;
        @(negedge clk_i);
        if (m_kind == 0) begin
          mtvec_i = $urandom;
          mepc_i = $urandom;
          if ($urandom_range(0, 5) == 0) mtvec_i[31:8] = '1;
        end
        drive($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), $urandom_range(0, 2) != 0,
              {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) == 0}, $urandom);
        redirect_ready_i = $urandom;
        #1;
        irq_c = first_code({mstatus_ie_i & mie_external_i & mip_external_i,
                            mstatus_ie_i & mie_software_i & mip_software_i,
                            mstatus_ie_i & mie_timer_i & mip_timer_i}, 11, 3, 7);
        exc_c = first_code({illegal_i, ebreak_i, ecall_i}, 2, 3, 11);
        take_trap = inst_valid_i && (irq_c >= 0 || exc_c >= 0);
        take_mret = inst_valid_i && !take_trap && mret_i;
        save  = m_kind == 1 && m_age == 0;
        redir = (m_kind == 1 && m_age > 0) || m_kind == 2;
        expect_all($sformatf("rnd%0d", n), save, save ? m_cause : 4'd0, save && m_intr, save,
                   save ? m_epc : 32'd0, save, m_kind == 2 && m_age == 0,
                   m_kind != 0 || take_trap || take_mret, redir, redir ? m_tgt : 32'd0);
        if (m_kind == 0) begin
          if (take_trap) begin
            m_kind = 1;
            m_age = 0;
            m_intr = irq_c >= 0;
            m_cause = 4'(m_intr ? irq_c : exc_c);
            m_epc = inst_pc_i;
            m_tgt = (mtvec_i & ~32'd3) + ((m_intr && mtvec_i[1:0] == 2'b01) ? 32'(4 * m_cause) : 32'd0);
          end else if (take_mret) begin
            m_kind = 2;
            m_age = 0;
            m_tgt = mepc_i & ~32'd3;
          end
        end else if (m_kind == 1 && m_age == 0)
          m_age = 1;
        else if (redirect_ready_i)
          m_kind = 0;
        else
          m_age++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
